// File: rtl/dmem_wait_model_pkg.sv
// Shared types and widths for the wait-state data memory model.
// Imported by the bus interface, the byte-merge helper and the top.
package dmem_wait_model_pkg;

  localparam int BYTEEN_W = 4;
  localparam int WORD_W   = 32;
  localparam int WAIT_W   = 4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_wait_model_if.sv
// CPU data-port bundle: the requester drives through the master modport,
// the memory model answers through the slave modport.
interface dmem_wait_model_if;
  import dmem_wait_model_pkg::*;

  logic                req;
  logic [31:0]         addr;
  logic [BYTEEN_W-1:0] byteen;
  logic [WORD_W-1:0]   wdata;
  logic [31:0]         inst_addr;
  logic [WORD_W-1:0]   rdata;
  logic                ready;
  logic                addr_err;
  logic                busy;

  modport master (
    output req, addr, byteen, wdata, inst_addr,
    input  rdata, ready, addr_err, busy
  );

  modport slave (
    input  req, addr, byteen, wdata, inst_addr,
    output rdata, ready, addr_err, busy
  );

endinterface

// File: rtl/dmem_wait_model_byte_merge.sv
// Per-lane merge of write data into an existing word: lane i takes
// wdata when its byte enable is set, otherwise keeps the old byte.
module dmem_byte_merge
  import dmem_wait_model_pkg::*;
(
  input  logic [WORD_W-1:0]   i_old,
  input  logic [WORD_W-1:0]   i_wdata,
  input  logic [BYTEEN_W-1:0] i_byteen,
  output logic [WORD_W-1:0]   o_merged
);

  for (genvar g = 0; g < BYTEEN_W; g++) begin : g_lane
    assign o_merged[8*g +: 8] = i_byteen[g] ? i_wdata[8*g +: 8] : i_old[8*g +: 8];
  end

endmodule

// File: rtl/dmem_wait_model.sv
// Word-organised data memory with req/ready latency, clear-on-reset sweep
// and range checking. Optional write trace enabled by DMEM_TRACE_EN.
module dmem_wait_model
  import dmem_wait_model_pkg::*;
#(
  parameter int          DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic           clk,
  input  logic           reset,
  dmem_wait_model_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_e              r_state;
  state_e              w_next;
  logic [CW-1:0]       r_clr_idx;
  logic [WAIT_W-1:0]   r_wait_cnt;

  logic [31:0]         r_addr;
  logic [BYTEEN_W-1:0] r_byteen;
  logic [WORD_W-1:0]   r_wdata;
  logic [31:0]         r_inst_addr;

  logic [WORD_W-1:0]   r_mem [DEPTH];

  logic [WORD_W-1:0]   r_rdata;
  logic                r_ready;
  logic                r_addr_err;
  logic                w_busy;

  logic                w_accept;
  logic                w_exec;
  logic                w_in_range;
  logic                w_we;
  logic [31:0]         w_op_addr;
  logic [BYTEEN_W-1:0] w_op_be;
  logic [WORD_W-1:0]   w_op_wdata;
  logic [31:0]         w_op_inst;
  logic [31:0]         w_off;
  logic [AW-1:0]       w_idx;
  logic [WORD_W-1:0]   w_old;
  logic [WORD_W-1:0]   w_merged;
  logic                w_unused;

  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_RESP)) && bus.req;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_clr_idx == CW'(DEPTH - 1)) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_INIT;
        end
      end
      ST_IDLE, ST_RESP: begin
        if (w_accept) begin
          w_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_BUSY;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (r_wait_cnt == WAIT_W'(1)) begin
          w_next = ST_RESP;
        end else begin
          w_next = ST_BUSY;
        end
      end
      default: w_next = ST_INIT;
    endcase
  end

  // Output decode from state
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      ST_INIT: w_busy = 1'b1;
      ST_BUSY: w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Sweep index, wait counter and latched request fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clr_idx   <= '0;
      r_wait_cnt  <= '0;
      r_addr      <= 32'h0;
      r_byteen    <= '0;
      r_wdata     <= '0;
      r_inst_addr <= 32'h0;
    end else begin
      if (r_state == ST_INIT) begin
        r_clr_idx <= r_clr_idx + CW'(1);
      end
      if (w_accept) begin
        r_addr      <= bus.addr;
        r_byteen    <= bus.byteen;
        r_wdata     <= bus.wdata;
        r_inst_addr <= bus.inst_addr;
        r_wait_cnt  <= WAIT_W'(WAIT_CYCLES);
      end else if (r_state == ST_BUSY) begin
        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
      end
    end
  end

  // With no wait states the access completes on the accepting edge, so the
  // live bus fields are used; from BUSY the latched copy is used instead.
  always_comb begin
    if (r_state == ST_BUSY) begin
      w_op_addr  = r_addr;
      w_op_be    = r_byteen;
      w_op_wdata = r_wdata;
      w_op_inst  = r_inst_addr;
    end else begin
      w_op_addr  = bus.addr;
      w_op_be    = bus.byteen;
      w_op_wdata = bus.wdata;
      w_op_inst  = bus.inst_addr;
    end
  end

  assign w_off      = w_op_addr - BASE_ADDR;
  assign w_in_range = (w_op_addr >= BASE_ADDR) && ({2'b00, w_off[31:2]} < 32'(DEPTH));
  assign w_idx      = w_off[AW+1:2];
  assign w_old      = r_mem[w_idx];
  assign w_exec     = (w_next == ST_RESP);
  assign w_we       = w_exec && w_in_range && (w_op_be != {BYTEEN_W{1'b0}});

  dmem_byte_merge u_merge (
    .i_old    (w_old),
    .i_wdata  (w_op_wdata),
    .i_byteen (w_op_be),
    .o_merged (w_merged)
  );

  // Memory array: sweep clear during INIT, merged writes on completion
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_clr_idx[AW-1:0]] <= '0;
    end else if (w_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // Registered completion outputs; rdata holds between completions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
    end else if (w_exec) begin
      r_ready    <= 1'b1;
      r_addr_err <= ~w_in_range;
      if (!w_in_range) begin
        r_rdata <= '0;
      end else if (w_op_be != {BYTEEN_W{1'b0}}) begin
        r_rdata <= w_merged;
      end else begin
        r_rdata <= w_old;
      end
    end else begin
      r_ready    <= 1'b0;
      r_addr_err <= 1'b0;
    end
  end

`ifdef DMEM_TRACE_EN
  // Write trace of every completed in-range store
  always @(posedge clk) begin
    if (!reset && w_we) begin
      $display("%d@%h: *%h <= %h", $time, w_op_inst, {w_op_addr[31:2], 2'b00}, w_merged);
    end
  end
  assign w_unused = ^w_off[1:0];
`else
  assign w_unused = ^{w_op_inst, w_off[1:0]};
`endif

  assign bus.rdata    = r_rdata;
  assign bus.ready    = r_ready;
  assign bus.addr_err = r_addr_err;
  assign bus.busy     = w_busy;

endmodule

// File: tb/tb_dmem_wait_model.sv
// Self-checking bench: three 16-word instances (wait 0 / wait 3 with base
// 0x1000 / wait 5) driven by directed and random ops against a word model.
module tb_dmem_wait_model;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        t_rst   [3];
  logic        t_req   [3];
  logic [31:0] t_addr  [3];
  logic [3:0]  t_be    [3];
  logic [31:0] t_wdata [3];
  logic [31:0] t_inst  [3];
  logic [31:0] o_rdata [3];
  logic        o_ready [3];
  logic        o_err   [3];
  logic        o_busy  [3];

  logic [31:0] m_mem [3][16];
  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_wait_model_if u_if ();
    assign u_if.req       = t_req[g];
    assign u_if.addr      = t_addr[g];
    assign u_if.byteen    = t_be[g];
    assign u_if.wdata     = t_wdata[g];
    assign u_if.inst_addr = t_inst[g];
    assign o_rdata[g]     = u_if.rdata;
    assign o_ready[g]     = u_if.ready;
    assign o_err[g]       = u_if.addr_err;
    assign o_busy[g]      = u_if.busy;

    dmem_wait_model #(
      .DEPTH       (16),
      .BASE_ADDR   ((g == 1) ? 32'h0000_1000 : 32'h0),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 3 : 5))
    ) u_dut (
      .clk   (clk),
      .reset (t_rst[g]),
      .bus   (u_if.slave)
    );
  end

  function automatic longint base_of(input int k);
    return (k == 1) ? 64'h1000 : 64'h0;
  endfunction

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Word-level reference: in range when base <= a < base + 16 words
  task automatic model_op(input int k, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd, output logic [31:0] rd, output logic err);
    longint la;
    int     idx;
    logic [31:0] w;
    la = longint'(a);
    if (la < base_of(k) || la >= base_of(k) + 64) begin
      err = 1'b1;
      rd  = 32'h0;
    end else begin
      err = 1'b0;
      idx = int'((la - base_of(k)) / 4);
      w   = m_mem[k][idx];
      for (int b = 0; b < 4; b++) begin
        if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      end
      m_mem[k][idx] = w;
      rd = w;
    end
  endtask

  task automatic issue(input int k, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input bit keep, input string tag);
    logic [31:0] er;
    logic        ee;
    int          n;
    model_op(k, a, be, wd, er, ee);
    t_addr[k]  = a;
    t_be[k]    = be;
    t_wdata[k] = wd;
    t_inst[k]  = $urandom;
    t_req[k]   = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1 && wait_of(k) > 0) chk({tag, "/busy"}, 32'(o_busy[k]), 32'd1);
    end while (!o_ready[k] && n < 40);
    chk({tag, "/ready"}, 32'(o_ready[k]), 32'd1);
    chk({tag, "/lat"}, 32'(n), 32'(wait_of(k) + 1));
    chk({tag, "/rdata"}, o_rdata[k], er);
    chk({tag, "/err"}, 32'(o_err[k]), 32'(ee));
    if (!keep) begin
      t_req[k] = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, "/pulse"}, 32'(o_ready[k]), 32'd0);
    end
  endtask

  task automatic wait_init(input int k, input string tag);
    int n;
    n = 0;
    while (o_busy[k] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(n), 32'd16);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  be;
    bit          keep;
    for (int k = 0; k < 3; k++) begin
      t_rst[k] = 1'b1;
      t_req[k] = 1'b0;
      t_addr[k] = 32'h0;
      t_be[k] = 4'h0;
      t_wdata[k] = 32'h0;
      t_inst[k] = 32'h0;
      for (int w = 0; w < 16; w++) m_mem[k][w] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst/rdata", o_rdata[k], 32'h0);
      chk("rst/ready", 32'(o_ready[k]), 32'd0);
      chk("rst/err", 32'(o_err[k]), 32'd0);
      chk("rst/busy", 32'(o_busy[k]), 32'd1);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) t_rst[k] = 1'b0;
    wait_init(0, "t1/init_len");

    issue(0, 32'h3C, 4'b0000, 32'h0, 1'b0, "t1/rd3c");
    issue(0, 32'h10, 4'b1111, 32'h1234_5678, 1'b0, "t2/wr");
    issue(0, 32'h10, 4'b0000, 32'h0, 1'b0, "t2/rd");
    issue(0, 32'h10, 4'b0100, 32'hAABB_CCDD, 1'b0, "t3/wr");
    chk("t3/const", o_rdata[0], 32'h12BB_5678);
    issue(0, 32'h12, 4'b0000, 32'h0, 1'b0, "t3/rd");

    issue(1, 32'h1008, 4'b1111, 32'h0BAD_F00D, 1'b1, "t4/first");
    issue(1, 32'h1008, 4'b0011, 32'h5555_AAAA, 1'b1, "t4/b2b");
    issue(1, 32'h1008, 4'b0000, 32'h0, 1'b0, "t4/rd");

    issue(1, 32'h1040, 4'b1111, 32'hFFFF_FFFF, 1'b0, "t5/hi");
    issue(1, 32'h0FFC, 4'b0000, 32'h0, 1'b0, "t5/lo");
    issue(1, 32'h103C, 4'b1000, 32'h7700_0000, 1'b0, "t5/last");

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 25; i++) begin
        a = 32'(base_of(k)) + 32'($urandom_range(0, 18) * 4) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = 32'(base_of(k)) - 32'($urandom_range(1, 3) * 4);
        be = ($urandom_range(0, 1) == 1) ? 4'b0000 : 4'($urandom_range(1, 15));
        keep = (i < 24) && ($urandom_range(0, 1) == 1);
        issue(k, a, be, $urandom, keep, "rnd");
      end
    end

    issue(2, 32'h14, 4'b1111, 32'hCAFE_F00D, 1'b0, "t6/pre");
    t_addr[2]  = 32'h8;
    t_be[2]    = 4'b1111;
    t_wdata[2] = 32'hDEAD_BEEF;
    t_req[2]   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6/busy_before", 32'(o_busy[2]), 32'd1);
    t_rst[2] = 1'b1;
    #1;
    chk("t6/ready", 32'(o_ready[2]), 32'd0);
    chk("t6/rdata", o_rdata[2], 32'h0);
    chk("t6/err", 32'(o_err[2]), 32'd0);
    chk("t6/busy", 32'(o_busy[2]), 32'd1);
    t_req[2] = 1'b0;
    for (int w = 0; w < 16; w++) m_mem[2][w] = 32'h0;
    @(negedge clk);
    t_rst[2] = 1'b0;
    wait_init(2, "t6/init_len");
    issue(2, 32'h8, 4'b0000, 32'h0, 1'b0, "t6/rd8");
    issue(2, 32'h14, 4'b0000, 32'h0, 1'b0, "t6/rd14");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
